// File: rtl/xsz_dnsz_seq.sv
// rtl/xsz_dnsz_seq.sv - registered downsizer: one wide beat in, R - start_lane narrow beats out.
module xsz_dnsz_seq #(
  parameter int M  = 3,
  parameter int N  = 2,
  parameter int A  = 19,
  parameter int DI = 64,
  parameter int DO = 32,
  parameter int PI = 102,
  parameter int PO = 66
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_s,
  output logic          rdy_s,
  input  logic [PI-1:0] pld_s,
  output logic          vld_m,
  input  logic          rdy_m,
  output logic [PO-1:0] pld_m,
  output logic          lst_m
);

  localparam int SI   = DI / 8;
  localparam int SO   = DO / 8;
  localparam int R    = DI / DO;
  localparam int IDW  = $clog2(N) + $clog2(M);
  localparam int HW   = PI - SI - DI;
  localparam int SIB  = $clog2(SI);
  localparam int SOB  = $clog2(SO);
  localparam int LW   = $clog2(R);
  localparam int AOFF = HW - 1 - IDW;
  localparam int ALSB = PI - IDW - A;

  if (DI <= DO || (DI % DO) != 0 || (R & (R - 1)) != 0 || (DO % 8) != 0 ||
      PO != PI - DI - SI + DO + SO || HW < IDW + A || A < SIB) begin : g_bad_params
    $error("xsz_dnsz_seq: illegal parameter combination");
  end

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t          r_state;
  logic [LW-1:0]   r_lane;
  logic [HW-1:0]   r_hdr;
  logic [SI-1:0]   r_strb;
  logic [DI-1:0]   r_data;
  logic            r_vld_m;
  logic            r_lst_m;
  logic [PO-1:0]   r_pld_m;

  logic            w_hs_m;
  logic            w_acc;
  logic [HW-1:0]   w_src_hdr;
  logic [SI-1:0]   w_src_strb;
  logic [DI-1:0]   w_src_data;
  logic [LW-1:0]   w_nlane;
  logic            w_first;
  logic [A-1:0]    w_naddr;
  logic [HW-1:0]   w_nhdr;
  logic [PO-1:0]   w_nbeat;
  logic            w_nlst;

  assign w_hs_m = r_vld_m && rdy_m;
  assign rdy_s  = (r_state == ST_IDLE) || (w_hs_m && r_lst_m);
  assign w_acc  = vld_s && rdy_s;

  assign vld_m = r_vld_m;
  assign lst_m = r_lst_m;
  assign pld_m = r_pld_m;

  // Next narrow beat comes from pld_s on accept, otherwise from the held wide beat.
  always_comb begin
    w_src_hdr  = r_hdr;
    w_src_strb = r_strb;
    w_src_data = r_data;
    w_nlane    = r_lane + LW'(1);
    w_first    = 1'b0;
    if (w_acc) begin
      w_src_hdr  = pld_s[PI-1 -: HW];
      w_src_strb = pld_s[DI +: SI];
      w_src_data = pld_s[DI-1:0];
      w_nlane    = pld_s[ALSB + SOB +: LW];
      w_first    = 1'b1;
    end
    w_naddr = w_src_hdr[AOFF -: A];
    w_naddr[SOB +: LW] = w_nlane;
    if (!w_first) begin
      for (int i = 0; i < SOB; i++) w_naddr[i] = 1'b0;
    end
    w_nhdr = w_src_hdr;
    w_nhdr[AOFF -: A] = w_naddr;
    w_nbeat = {w_nhdr, w_src_strb[int'(w_nlane) * SO +: SO],
               w_src_data[int'(w_nlane) * DO +: DO]};
    w_nlst  = (w_nlane == LW'(R - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lane  <= '0;
      r_hdr   <= '0;
      r_strb  <= '0;
      r_data  <= '0;
      r_vld_m <= 1'b0;
      r_lst_m <= 1'b0;
      r_pld_m <= '0;
    end else if (w_acc) begin
      r_hdr   <= w_src_hdr;
      r_strb  <= w_src_strb;
      r_data  <= w_src_data;
      r_lane  <= w_nlane;
      r_state <= ST_SEND;
      r_vld_m <= 1'b1;
      r_pld_m <= w_nbeat;
      r_lst_m <= w_nlst;
    end else if (w_hs_m) begin
      if (r_lst_m) begin
        r_state <= ST_IDLE;
        r_vld_m <= 1'b0;
        r_lst_m <= 1'b0;
      end else begin
        r_lane  <= w_nlane;
        r_pld_m <= w_nbeat;
        r_lst_m <= w_nlst;
      end
    end
  end

endmodule
